// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control definitions: ALU control codes and multiplier FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: alu_ctrl_e (4-bit ALU control codes, SMUL=13), mul_state_e (2-bit),
//           multiplier width constants.
package cpu_ctrl_pkg;

   // ALU control codes produced by the ALU control stage
   typedef enum logic [3:0] {
      ALU_AND  = 4'd0,
      ALU_OR   = 4'd1,
      ALU_ADD  = 4'd2,
      ALU_XOR  = 4'd3,
      ALU_SLL  = 4'd4,
      ALU_SRL  = 4'd5,
      ALU_SUB  = 4'd6,
      ALU_SLT  = 4'd7,
      ALU_SRA  = 4'd8,
      ALU_SMUL = 4'd13
   } alu_ctrl_e;

   // Sequential multiplier states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mul_state_e;

   localparam int MUL_W = 32;
   // Accumulator carries one guard bit so that subtracting -2^31 cannot overflow
   localparam int ACC_W = MUL_W + 1;
   localparam logic [5:0] ITER_LAST = 6'd31;

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: recode {mplier[0], q_m1}, add/sub/none, arithmetic shift right.
// Latency: combinational, zero cycles.
// Backpressure: none; purely combinational, holds no state.
// Ports: acc/mplier/q_m1 = current partial-product state, mcand = sign-extended multiplicand,
//        acc_nxt/mplier_nxt/q_m1_nxt = state after this step.
module booth_step
   import cpu_ctrl_pkg::*;
(
   input  logic [ACC_W-1:0] acc,
   input  logic [MUL_W-1:0] mplier,
   input  logic             q_m1,
   input  logic [ACC_W-1:0] mcand,
   output logic [ACC_W-1:0] acc_nxt,
   output logic [MUL_W-1:0] mplier_nxt,
   output logic             q_m1_nxt
);

   logic [ACC_W-1:0] sum;

   always_comb begin
      sum = acc;
      case ({mplier[0], q_m1})
         2'b01:   sum = acc + mcand;  // end of a run of ones
         2'b10:   sum = acc - mcand;  // start of a run of ones
         default: sum = acc;
      endcase
      // Arithmetic shift right of the concatenation {sum, mplier, q_m1}
      acc_nxt    = {sum[ACC_W-1], sum[ACC_W-1:1]};
      mplier_nxt = {sum[0], mplier[MUL_W-1:1]};
      q_m1_nxt   = mplier[0];
   end

endmodule

// File: rtl/mul_seq_unit.sv
// Sequential signed 32x32 multiplier (radix-2 Booth, one step per cycle), low 32 bits of product.
// Latency: start accepted in cycle N -> RUN N+1..N+32 -> DONE (done_o, result_o) in N+33.
// Backpressure: busy_o stalls the pipeline during RUN; start_i is ignored while running.
// Ports: clk_i, rst_i (sync, active-high), start_i, ALUCtrl_i (acts on SMUL only), src1_i, src2_i,
//        result_o (held until next DONE), busy_o (RUN only), done_o (one-cycle pulse in DONE).
// Build option: MUL_ZERO_SKIP_EN -- a zero operand goes straight to DONE in N+1 with result 0.
module mul_seq_unit
   import cpu_ctrl_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [3:0]       ALUCtrl_i,
   input  logic [MUL_W-1:0] src1_i,
   input  logic [MUL_W-1:0] src2_i,
   output logic [MUL_W-1:0] result_o,
   output logic             busy_o,
   output logic             done_o
);

   mul_state_e       state;
   logic [5:0]       cnt;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] mcand;
   logic [MUL_W-1:0] mplier;
   logic             q_m1;

   logic [ACC_W-1:0] acc_step;
   logic [MUL_W-1:0] mplier_step;
   logic             q_m1_step;

   logic start_ok;
   logic zero_skip;

   booth_step u_booth_step (
      .acc        (acc),
      .mplier     (mplier),
      .q_m1       (q_m1),
      .mcand      (mcand),
      .acc_nxt    (acc_step),
      .mplier_nxt (mplier_step),
      .q_m1_nxt   (q_m1_step)
   );

   assign start_ok = start_i && (ALUCtrl_i == ALU_SMUL) &&
                     ((state == ST_IDLE) || (state == ST_DONE));

`ifdef MUL_ZERO_SKIP_EN
   assign zero_skip = (src1_i == '0) || (src2_i == '0);
`else
   assign zero_skip = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         q_m1     <= 1'b0;
         result_o <= '0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               done_o <= 1'b0;
               busy_o <= 1'b0;
               if (start_ok) begin
                  if (zero_skip) begin
                     state    <= ST_DONE;
                     result_o <= '0;
                     done_o   <= 1'b1;
                  end else begin
                     state  <= ST_RUN;
                     busy_o <= 1'b1;
                     cnt    <= '0;
                     acc    <= '0;
                     mcand  <= {src1_i[MUL_W-1], src1_i};
                     mplier <= src2_i;
                     q_m1   <= 1'b0;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               acc    <= acc_step;
               mplier <= mplier_step;
               q_m1   <= q_m1_step;
               if (cnt == ITER_LAST) begin
                  // After the last shift the low product half sits in the multiplier register
                  state    <= ST_DONE;
                  busy_o   <= 1'b0;
                  done_o   <= 1'b1;
                  result_o <= mplier_step;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_o <= 1'b0;
               done_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_seq_unit.sv
// Scoreboard bench for mul_seq_unit: issued multiplies push expected (done cycle, result) entries,
// a negedge monitor checks done_o/busy_o/result_o every cycle against the queue head.
// Ports: drives every DUT port; clock period 10.
module tb_mul_seq_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [3:0]  ALUCtrl_i;
   logic [31:0] src1_i;
   logic [31:0] src2_i;
   logic [31:0] result_o;
   logic        busy_o;
   logic        done_o;

   mul_seq_unit dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (start_i),
      .ALUCtrl_i (ALUCtrl_i),
      .src1_i    (src1_i),
      .src2_i    (src2_i),
      .result_o  (result_o),
      .busy_o    (busy_o),
      .done_o    (done_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          issue;
      int          done_cyc;
      logic [31:0] res;
   } op_t;

   op_t         sb[$];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   logic        chk_en = 1'b0;
   logic [31:0] last_res = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=0x%08h want=0x%08h", name, cyc, act, exp);
      end
   endtask

   // Reference: full 64-bit signed product, keep low word
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      longint pa;
      longint pb;
      longint p;
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      p  = pa * pb;
      return p[31:0];
   endfunction

   always @(posedge clk_i) cyc <= cyc + 1;

   // A reset sampled at this edge wipes every in-flight operation and the held result
   always @(posedge clk_i) begin
      if (rst_i === 1'b1) begin
         sb.delete();
         last_res = '0;
         chk_en   = 1'b1;
      end
   end

   always @(negedge clk_i) begin
      if (chk_en) begin
         logic exp_done;
         logic exp_busy;
         exp_done = (sb.size() > 0) && (sb[0].done_cyc == cyc);
         exp_busy = (sb.size() > 0) && (cyc > sb[0].issue) && (cyc < sb[0].done_cyc);
         chk("done_o", {31'd0, done_o}, {31'd0, exp_done});
         chk("busy_o", {31'd0, busy_o}, {31'd0, exp_busy});
         if (exp_done) begin
            last_res = sb[0].res;
            void'(sb.pop_front());
         end
         chk("result_o", result_o, last_res);
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
      start_i   = 1'b0;
      ALUCtrl_i = 4'd0;
      rst_i     = 1'b0;
   endtask

   // Drive a start in the current cycle; the model decides whether the DUT may accept it
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl);
      op_t e;
      int  lat;
      start_i   = 1'b1;
      ALUCtrl_i = ctrl;
      src1_i    = a;
      src2_i    = b;
      if (!rst_i && ctrl == 4'd13 && (sb.size() == 0 || sb[$].done_cyc <= cyc)) begin
         lat = 33;
`ifdef MUL_ZERO_SKIP_EN
         if (a == 32'd0 || b == 32'd0) lat = 1;
`endif
         e.issue    = cyc;
         e.done_cyc = cyc + lat;
         e.res      = ref_mul(a, b);
         sb.push_back(e);
      end
   endtask

   task automatic wait_idle();
      int g = 0;
      while (sb.size() != 0 && g < 100) begin
         tick();
         g++;
      end
      tick();
      chk("wait_idle", sb.size(), 0);
   endtask

   // Advance to the DONE cycle of the newest operation (or stay if nothing is pending)
   task automatic wait_done_slot();
      int g = 0;
      while (sb.size() != 0 && sb[$].done_cyc > cyc && g < 100) begin
         tick();
         g++;
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'd0;
         3:       return 32'($signed($urandom_range(0, 40)) - 20);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst_i     = 1'b1;
      start_i   = 1'b0;
      ALUCtrl_i = 4'd0;
      src1_i    = '0;
      src2_i    = '0;
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      tick();

      // Directed corner products
      issue(32'd7, 32'hFFFF_FFFD, 4'd13);           tick(); wait_idle();
      issue(32'h8000_0000, 32'hFFFF_FFFF, 4'd13);   tick(); wait_idle();
      issue(32'h8000_0000, 32'h8000_0000, 4'd13);   tick(); wait_idle();

      // Non-SMUL control code is ignored
      issue(32'd9, 32'd9, 4'd4);                    tick();
      repeat (5) tick();

      // Start pulsed mid-RUN is ignored
      issue(32'd1234, 32'hFFFF_0001, 4'd13);        tick();
      repeat (4) tick();
      issue(32'd55, 32'd66, 4'd13);                 tick();
      wait_idle();

      // Reset at RUN iteration 10 aborts; nothing follows for 40 cycles
      issue(32'd11, 32'd13, 4'd13);
      repeat (11) tick();
      rst_i = 1'b1;
      tick();
      repeat (40) tick();

      // Back-to-back: second start in DONE cycle of the first
      issue(32'hFFFF_FF00, 32'd3, 4'd13);           tick();
      wait_done_slot();
      issue(32'd5, 32'd6, 4'd13);                   tick();
      wait_idle();

      // Zero operand: latency depends on build option
      issue(32'd0, 32'd123, 4'd13);                 tick(); wait_idle();

      // Reset wins over a simultaneous start
      rst_i = 1'b1;
      issue(32'd3, 32'd3, 4'd13);                   tick();
      repeat (3) tick();

      // Randomised traffic with back-to-back starts, stray codes and mid-run pulses
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         logic [3:0]  ctrl;
         a    = pick();
         b    = pick();
         ctrl = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 12)) : 4'd13;
         if ($urandom_range(0, 2) == 0) begin
            wait_done_slot();
         end else begin
            wait_idle();
            repeat ($urandom_range(0, 3)) tick();
         end
         issue(a, b, ctrl);
         tick();
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 20)) tick();
            issue(pick(), pick(), 4'd13);
            tick();
         end
      end
      wait_idle();
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
